// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin / fixed-priority memory arbiter.
package mem_arbiter_rr_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DDATA_W_DEF = 32;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Round-robin pointer successor: the port just served moves to lowest priority.
  function automatic int next_port(input int idx, input int nport);
    return (idx + 1) % nport;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating priority picker: first requester found scanning upward from ptr_i.
module rr_priority_picker
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NPORT = 2
) (
  input  logic [NPORT-1:0]         req_i,
  input  logic [$clog2(NPORT)-1:0] ptr_i,
  output logic [NPORT-1:0]         gnt_o,
  output logic [$clog2(NPORT)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NPORT);

  logic             found;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      cand     = (int'(ptr_i) + i) % NPORT;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: one registered transaction at a time on a single memory channel,
// round-robin or fixed-priority grant, one-cycle completion pulse per port.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NPORT   = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DDATA_W = DDATA_W_DEF,
  parameter int MODE    = MODE_RR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORT-1:0]             reqIn,
  input  logic [NPORT*ADDR_W-1:0]      addrIn,
  input  logic [NPORT*DDATA_W-1:0]     wdataIn,
  input  logic [NPORT*(DDATA_W/8)-1:0] wstrbIn,
  input  logic [NPORT-1:0]             wrIn,
  output logic [NPORT-1:0]             readyOut,
  output logic [DDATA_W-1:0]           rdataOut,
  output logic [NPORT-1:0]             grantOut,
  output logic                         memBusyOut,
  output logic                         memReq,
  output logic [ADDR_W-1:0]            memAddr,
  output logic                         memWr,
  output logic [DDATA_W-1:0]           memDataOut,
  output logic [DDATA_W/8-1:0]         memStrb,
  input  logic                         memAck,
  input  logic [DDATA_W-1:0]           memDataIn
);

  localparam int STRB_W = DDATA_W / 8;
  localparam int IDX_W  = $clog2(NPORT);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [NPORT-1:0]   grant_q, grant_d;
  logic [NPORT-1:0]   ready_q, ready_d;
  logic [DDATA_W-1:0] rdata_q, rdata_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [DDATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]  strb_q, strb_d;

  logic [IDX_W-1:0]   ptr_sel;
  logic [NPORT-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;

  // Fixed priority is the rotating picker with its pointer pinned at port 0.
  assign ptr_sel = (MODE == MODE_FIXED) ? '0 : ptr_q;

  rr_priority_picker #(
    .NPORT(NPORT)
  ) u_picker (
    .req_i (reqIn),
    .ptr_i (ptr_sel),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ready_d = '0;
    rdata_d = rdata_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;

    case (state_q)
      ST_IDLE: begin
        if (|reqIn) begin
          gidx_d  = pick_idx;
          grant_d = pick_gnt;
          addr_d  = addrIn[int'(pick_idx)*ADDR_W +: ADDR_W];
          wr_d    = wrIn[pick_idx];
          wdata_d = wdataIn[int'(pick_idx)*DDATA_W +: DDATA_W];
          strb_d  = wrIn[pick_idx] ? wstrbIn[int'(pick_idx)*STRB_W +: STRB_W] : '1;
          req_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Completion is owed to the granted port even if it dropped its request meanwhile.
        if (memAck) begin
          rdata_d = memDataIn;
          req_d   = 1'b0;
          ready_d = grant_q;
          if (MODE == MODE_RR) begin
            ptr_d = IDX_W'(next_port(int'(gidx_q), NPORT));
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  assign readyOut   = ready_q;
  assign rdataOut   = rdata_q;
  assign grantOut   = grant_q;
  assign memBusyOut = (state_q != ST_IDLE);
  assign memReq     = req_q;
  assign memAddr    = addr_q;
  assign memWr      = wr_q;
  assign memDataOut = wdata_q;
  assign memStrb    = strb_q;

endmodule
